// File: rtl/ssd_scan_ctl_if.sv
// Handshake bundle between the display value source and the scan controller.
// The source drives value/load/lz_blank; the scanner drives the decoder/anode side.
interface ssd_scan_ctl_if;
  logic [15:0] value;
  logic        load;
  logic        lz_blank;
  logic [3:0]  ssd_in;
  logic [3:0]  ssd_ctl;
  logic [1:0]  digit_idx;
  logic        frame_done;

  modport master (
    output value, load, lz_blank,
    input  ssd_in, ssd_ctl, digit_idx, frame_done
  );

  modport slave (
    input  value, load, lz_blank,
    output ssd_in, ssd_ctl, digit_idx, frame_done
  );
endinterface

// File: rtl/ssd_scan_ctl.sv
// 4-digit BCD scan controller for one shared seven-segment decoder.
// Values are double-buffered and only applied at frame boundaries.
module ssd_scan_ctl #(
  parameter int SCAN_DIV = 17
) (
  input  logic           clk,
  input  logic           rst,
  ssd_scan_ctl_if.slave  bus
);

  logic [SCAN_DIV-1:0] r_cnt;
  logic [1:0]          r_idx;
  logic [15:0]         r_disp;
  logic [15:0]         r_pend;
  logic                r_pend_v;
  logic                r_frame_done;

  logic w_tick;
  logic w_bound;
  logic w_lead0;
  logic w_blank;

  assign w_tick  = &r_cnt;
  assign w_bound = w_tick & (r_idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_disp       <= 16'h0;
      r_pend       <= 16'h0;
      r_pend_v     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt        <= r_cnt + 1'b1;
      r_frame_done <= w_bound;
      if (w_tick)
        r_idx <= r_idx + 2'd1;
      if (bus.load) begin
        r_pend   <= bus.value;
        r_pend_v <= 1'b1;
      end
      // Boundary commit: a same-cycle load beats the pending buffer.
      if (w_bound) begin
        r_pend_v <= 1'b0;
        if (bus.load)
          r_disp <= bus.value;
        else if (r_pend_v)
          r_disp <= r_pend;
      end
    end
  end

  always_comb begin
    w_lead0 = 1'b0;
    unique case (r_idx)
      2'd0: w_lead0 = 1'b0;
      2'd1: w_lead0 = (r_disp[15:4] == 12'h0);
      2'd2: w_lead0 = (r_disp[15:8] == 8'h0);
      2'd3: w_lead0 = (r_disp[15:12] == 4'h0);
    endcase
  end

  assign w_blank = bus.lz_blank & w_lead0;

  assign bus.ssd_ctl    = w_blank ? 4'b1111 : ~(4'b0001 << r_idx);
  assign bus.ssd_in     = w_blank ? 4'h0 : r_disp[4*r_idx +: 4];
  assign bus.digit_idx  = r_idx;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_ssd_scan_ctl.sv
// Scoreboard bench for ssd_scan_ctl with SCAN_DIV=2 (digit advances every 4 clk).
// Stimulus queues expected digit presentations; the monitor pops on each new digit.
module tb_ssd_scan_ctl;

  typedef struct {
    logic [3:0] ctl;
    logic [3:0] din;
    logic [1:0] idx;
    logic       fd;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t q[$];

  ssd_scan_ctl_if bus ();

  ssd_scan_ctl #(.SCAN_DIV(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_e(input logic [3:0] ctl, input logic [3:0] din,
                        input logic [1:0] idx, input logic fd);
    exp_t e;
    e.ctl = ctl;
    e.din = din;
    e.idx = idx;
    e.fd  = fd;
    q.push_back(e);
  endtask

  task automatic push_frame(input logic [15:0] v, input logic fd0);
    logic [3:0] ctl_tab [4];
    ctl_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int k = 0; k < 4; k++)
      push_e(ctl_tab[k], v[4*k +: 4], 2'(k), (k == 0) ? fd0 : 1'b0);
  endtask

  task automatic load_val(input logic [15:0] v);
    bus.value = v;
    bus.load  = 1'b1;
    step(1);
    bus.load  = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%b want=%b", nm, act, req);
    end
  endtask

  // Monitor: a change of digit_idx (or first cycle out of reset) is a new digit.
  logic       mon_first;
  logic [1:0] mon_prev;
  always @(negedge clk) begin
    logic chg;
    exp_t e;
    if (rst) begin
      mon_first = 1'b1;
      mon_prev  = 2'd0;
    end else begin
      chg = mon_first || (bus.digit_idx != mon_prev);
      if (chg) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_digit idx=%0d ctl=%b in=%h",
                   bus.digit_idx, bus.ssd_ctl, bus.ssd_in);
        end else begin
          e = q.pop_front();
          if (bus.ssd_ctl !== e.ctl || bus.ssd_in !== e.din ||
              bus.digit_idx !== e.idx || bus.frame_done !== e.fd) begin
            errors++;
            $display("FAIL scan got ctl=%b in=%h idx=%0d fd=%b want ctl=%b in=%h idx=%0d fd=%b",
                     bus.ssd_ctl, bus.ssd_in, bus.digit_idx, bus.frame_done,
                     e.ctl, e.din, e.idx, e.fd);
          end
        end
      end
      if (bus.frame_done === 1'b1) begin
        checks++;
        if (!(chg && !mon_first && bus.digit_idx == 2'd0)) begin
          errors++;
          $display("FAIL frame_done_pulse got=1 at idx=%0d want=0", bus.digit_idx);
        end
      end
      mon_prev  = bus.digit_idx;
      mon_first = 1'b0;
    end
  end

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.value    = 16'h0;
    bus.load     = 1'b0;
    bus.lz_blank = 1'b0;
    step(2);
    push_frame(16'h0000, 1'b0);
    rst = 1'b0;

    // Load at idx=1: held pending until the frame boundary, then kept.
    step(4);
    load_val(16'h1234);
    push_frame(16'h1234, 1'b1);
    push_frame(16'h1234, 1'b1);

    // Mid-scan reset at idx=2 of the second 1234 frame.
    step(36);
    rst = 1'b1;
    q.delete();
    #1;
    chk("rst_ctl", bus.ssd_ctl, 4'b1110);
    chk("rst_in", bus.ssd_in, 4'h0);
    chk("rst_fd", {3'b0, bus.frame_done}, 4'h0);
    chk("rst_idx", {2'b0, bus.digit_idx}, 4'h0);
    step(2);
    push_frame(16'h0000, 1'b0);
    push_frame(16'h0000, 1'b1);
    rst = 1'b0;

    // Back-to-back loads in one frame: last one wins.
    step(18);
    load_val(16'h1111);
    bus.value = 16'h9876;
    bus.load  = 1'b1;
    step(1);
    bus.load  = 1'b0;
    push_frame(16'h9876, 1'b1);

    // Pending 2222, then 5555 loaded exactly on the boundary edge.
    step(15);
    load_val(16'h2222);
    push_frame(16'h5555, 1'b1);
    push_frame(16'h5555, 1'b1);
    step(11);
    load_val(16'h5555);

    // Leading-zero blanking.
    bus.lz_blank = 1'b1;
    step(17);
    load_val(16'h0070);
    push_e(4'b1110, 4'h0, 2'd0, 1'b1);
    push_e(4'b1101, 4'h7, 2'd1, 1'b0);
    push_e(4'b1111, 4'h0, 2'd2, 1'b0);
    push_e(4'b1111, 4'h0, 2'd3, 1'b0);
    step(16);
    load_val(16'h0000);
    push_e(4'b1110, 4'h0, 2'd0, 1'b1);
    push_e(4'b1111, 4'h0, 2'd1, 1'b0);
    push_e(4'b1111, 4'h0, 2'd2, 1'b0);
    push_e(4'b1111, 4'h0, 2'd3, 1'b0);

    // Non-BCD pass-through, then no blanking with lz_blank=0.
    step(14);
    load_val(16'hA0F9);
    push_frame(16'hA0F9, 1'b1);
    step(14);
    bus.lz_blank = 1'b0;
    step(1);
    load_val(16'h0009);
    push_frame(16'h0009, 1'b1);
    push_frame(16'h0009, 1'b1);
    step(46);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got=%0d want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
